rf_wb_queue: RTL and testbench
==============================

RF_WB_QUEUE -- requirements
Module: rf_wb_queue

Interface
REQ-001 SHALL have parameter DW, default 8, register-file data width.
REQ-002 SHALL have parameter AW, default 11, link/stack address width; AW > DW; extension width EW = AW-DW.
REQ-003 SHALL have parameter RW, default 3, register index width.
REQ-004 SHALL have parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-005 SHALL have parameter LINK_REG, default 3'b011, link-register index.
REQ-006 SHALL have parameter JAL_OP, default 5'b11011, opcode that forces a link-register write.
REQ-007 SHALL provide ports clk in 1, rising-edge clock; rst_n in 1, synchronous active-low reset; one clock, reset is synchronous and active-low.
REQ-008 SHALL provide the following request ports: in_valid in 1; in_ready out 1; instr in 16 (destination = instr[RW-1:0]); opcode in 5; jal in 1.
REQ-009 SHALL provide the following data ports: lwra_data in AW (link/lw-ra value); stack_data in AW (stack read value); stackmux_data in DW (normal result).
REQ-010 SHALL provide the following write-back ports: wb_valid out 1; wb_ready in 1 (register-file accept); write_reg out RW; write_data out DW; write_data_ext out EW.
REQ-011 SHALL provide the following status/bypass ports: flush in 1; count out $clog2(DEPTH)+1; overflow out 1 (sticky); q_reg in RW; q_hit out 1; q_data out DW.

Function
REQ-012 SHALL form each entry at accept time:
- data = jal ? lwra_data[DW-1:0] : stackmux_data.
- ext = jal ? lwra_data[AW-1:DW] : stack_data[AW-1:DW].
- reg = (opcode==JAL_OP) ? LINK_REG : instr[RW-1:0].
REQ-013 SHALL select the destination by opcode only; jal=1 with opcode!=JAL_OP uses instr[RW-1:0].
REQ-014 SHALL accept a request on a cycle where in_valid && in_ready; the entry is written at that rising edge.
REQ-015 SHALL drive in_ready = (count < DEPTH) || (wb_valid && wb_ready), allowing push when full if a pop occurs in the same cycle.
REQ-016 SHALL drive wb_valid = (count != 0); write_reg, write_data and write_data_ext come from the head entry, registered, with no combinational path from request inputs.
REQ-017 SHALL complete a pop on a cycle where wb_valid && wb_ready; the head advances at that edge.
REQ-018 SHALL have a minimum latency of 1 cycle: a request accepted into an empty queue appears on wb_* the next cycle.
REQ-019 SHALL hold head outputs stable while wb_valid && !wb_ready.
REQ-020 SHALL keep count unchanged on a simultaneous push and pop; otherwise count is incremented or decremented by 1.
REQ-021 SHALL advance read and write pointers modulo DEPTH, wrapping from DEPTH-1 to 0.
REQ-022 SHALL set overflow when in_valid && !in_ready; it stays set until reset, and the request is dropped.
REQ-023 SHALL, on flush=1, empty the queue at the next edge: count=0, pointers=0, wb_valid=0 next cycle. A push or pop in the same cycle is discarded. Overflow is unaffected.
REQ-024 SHALL compute q_hit combinationally: 1 if any valid entry has reg==q_reg.
REQ-025 SHALL drive q_data from the youngest matching entry; q_data=0 when q_hit=0.
REQ-026 SHALL not include an entry popping in the current cycle in q_hit, but SHALL include an entry pushing in the current cycle.
REQ-027 SHALL keep all internal state and all outputs in the clk domain; no latches.

Reset
REQ-028 SHALL, when rst_n=0 at a rising edge, clear count, pointers and overflow; wb_valid=0; write_reg, write_data and write_data_ext=0; in_ready=1 the following cycle.
REQ-029 SHALL have reset take priority over flush, push and pop; reset asserted mid-stream discards all entries.
REQ-030 SHALL ensure q_hit=0 and q_data=0 while the queue is empty after reset.

Verification
REQ-031 SHALL be verified with a JAL link write: opcode=5'b11011, jal=1, lwra_data=11'h5A3, instr[2:0]=3'b110 -> next cycle wb_valid=1, write_reg=3, write_data=8'hA3, write_data_ext=3'b101.
REQ-032 SHALL be verified with a normal write: jal=0, opcode=0, stackmux_data=8'h7F, stack_data=11'h400, instr[2:0]=5 -> write_reg=5, write_data=8'h7F, write_data_ext=3'b100.
REQ-033 SHALL be verified with fill and stall: wb_ready=0, push 4 entries -> count=4, in_ready=0. A 5th push sets overflow=1 and the entry is dropped. Then wb_ready=1 with simultaneous push -> count stays 4, in_ready=1; entries drain in order with wrap-around.
REQ-034 SHALL be verified with bypass: push reg 2 data 8'h11, then reg 2 data 8'h22, wb_ready=0, q_reg=2 -> q_hit=1, q_data=8'h22; q_reg=4 -> q_hit=0, q_data=0.
REQ-035 SHALL be verified with flush and reset: with 3 entries, flush=1 -> next cycle count=0, wb_valid=0, overflow retained. rst_n=0 with entries queued -> next cycle all outputs 0, in_ready=1.

Source files
------------

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: register-file write-back queue.
//   Buffers register-file writes (destination, data, extension bits) in a
//   DEPTH-entry circular FIFO and presents the oldest entry on a
//   valid/ready write-back port. Also provides a combinational bypass lookup
//   (q_reg -> q_hit/q_data) over the queued and in-flight entries.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          request handshake
//   instr, opcode, jal         destination select and data select
//   lwra_data, stack_data,
//   stackmux_data              candidate data sources
//   wb_valid/wb_ready          write-back handshake
//   write_reg/_data/_data_ext  head entry
//   flush                      empty the queue at the next edge
//   count, overflow            occupancy, sticky dropped-request flag
//   q_reg/q_hit/q_data         bypass lookup
module rf_wb_queue #(
  parameter int              DW       = 8,
  parameter int              AW       = 11,
  parameter int              RW       = 3,
  parameter int              DEPTH    = 4,
  parameter logic [RW-1:0]   LINK_REG = 3'b011,
  parameter logic [4:0]      JAL_OP   = 5'b11011,
  localparam int             EW       = AW - DW,
  localparam int             PW       = $clog2(DEPTH),
  localparam int             CW       = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   instr,
  input  logic [4:0]    opcode,
  input  logic          jal,
  input  logic [AW-1:0] lwra_data,
  input  logic [AW-1:0] stack_data,
  input  logic [DW-1:0] stackmux_data,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [RW-1:0] write_reg,
  output logic [DW-1:0] write_data,
  output logic [EW-1:0] write_data_ext,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          overflow,
  input  logic [RW-1:0] q_reg,
  output logic          q_hit,
  output logic [DW-1:0] q_data
);

  typedef struct packed {
    logic [RW-1:0] rg;
    logic [DW-1:0] data;
    logic [EW-1:0] ext;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        new_e;
  logic [PW-1:0] rd_ptr, wr_ptr, idx;
  logic [CW-1:0] count_q;
  logic          push, pop;

  // Destination is chosen by opcode alone; jal only steers the data source.
  always_comb begin
    new_e.rg   = (opcode == JAL_OP) ? LINK_REG : instr[RW-1:0];
    new_e.data = jal ? lwra_data[DW-1:0]  : stackmux_data;
    new_e.ext  = jal ? lwra_data[AW-1:DW] : stack_data[AW-1:DW];
  end

  assign count          = count_q;
  assign wb_valid       = (count_q != '0);
  assign in_ready       = (count_q < CW'(DEPTH)) || (wb_valid && wb_ready);
  assign push           = in_valid && in_ready;
  assign pop            = wb_valid && wb_ready;
  // Head is read straight from storage, so outputs only change at an edge.
  assign write_reg      = mem[rd_ptr].rg;
  assign write_data     = mem[rd_ptr].data;
  assign write_data_ext = mem[rd_ptr].ext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (in_valid && !in_ready) overflow <= 1'b1;
      if (flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count_q <= '0;
      end else begin
        // Pointers are PW bits wide, so increment wraps modulo DEPTH.
        if (push) begin
          mem[wr_ptr] <= new_e;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count_q <= count_q + 1'b1;
        else if (pop && !push) count_q <= count_q - 1'b1;
      end
    end
  end

  // Bypass: walk oldest to youngest so the last match (youngest) wins.
  // The head is skipped when it pops this cycle; an accepted push is
  // treated as the youngest entry of all.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if ((CW'(k) < count_q) && !(k == 0 && pop) && (mem[idx].rg == q_reg)) begin
        q_hit  = 1'b1;
        q_data = mem[idx].data;
      end
    end
    if (push && !flush && (new_e.rg == q_reg)) begin
      q_hit  = 1'b1;
      q_data = new_e.data;
    end
  end

endmodule

// File: tb/tb_rf_wb_queue.sv
// tb_rf_wb_queue: directed self-checking bench for rf_wb_queue (defaults).
module tb_rf_wb_queue;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, jal, wb_valid, wb_ready, flush;
  logic        overflow, q_hit;
  logic [15:0] instr;
  logic [4:0]  opcode;
  logic [10:0] lwra_data, stack_data;
  logic [7:0]  stackmux_data, write_data, q_data;
  logic [2:0]  write_reg, write_data_ext, q_reg, count;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  rf_wb_queue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .opcode(opcode), .jal(jal), .lwra_data(lwra_data),
    .stack_data(stack_data), .stackmux_data(stackmux_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .write_reg(write_reg),
    .write_data(write_data), .write_data_ext(write_data_ext), .flush(flush),
    .count(count), .overflow(overflow), .q_reg(q_reg), .q_hit(q_hit),
    .q_data(q_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Normal (non-JAL) push setup: reg r, data d, stack ext from s.
  task automatic drive_norm(input logic [2:0] r, input logic [7:0] d, input logic [10:0] s);
    in_valid = 1'b1; jal = 1'b0; opcode = 5'd0;
    instr = {13'd0, r}; stackmux_data = d; stack_data = s;
  endtask

  initial begin
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h11; exp_q[1] = 8'h12; exp_q[2] = 8'h13; exp_q[3] = 8'h15;
    rst_n = 1'b0; in_valid = 1'b0; jal = 1'b0; wb_ready = 1'b0; flush = 1'b0;
    instr = '0; opcode = '0; lwra_data = '0; stack_data = '0;
    stackmux_data = '0; q_reg = '0;
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wdata", {write_reg, write_data, write_data_ext}, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_q_hit", q_hit, 0);
    chk("rst_q_data", q_data, 0);
    rst_n = 1'b1;

    // JAL link write; bypass sees the in-flight push.
    in_valid = 1'b1; opcode = 5'b11011; jal = 1'b1; lwra_data = 11'h5A3;
    instr = 16'h0006; q_reg = 3'd3; #1;
    chk("jal_bypass_hit", q_hit, 1);
    chk("jal_bypass_data", q_data, 8'hA3);
    step();
    in_valid = 1'b0; #1;
    chk("jal_wb_valid", wb_valid, 1);
    chk("jal_reg", write_reg, 3);
    chk("jal_data", write_data, 8'hA3);
    chk("jal_ext", write_data_ext, 3'b101);
    chk("jal_count", count, 1);
    wb_ready = 1'b1; step(); wb_ready = 1'b0;
    chk("jal_popped", wb_valid, 0);

    // Normal write.
    drive_norm(3'd5, 8'h7F, 11'h400);
    step(); in_valid = 1'b0; #1;
    chk("norm_reg", write_reg, 5);
    chk("norm_data", write_data, 8'h7F);
    chk("norm_ext", write_data_ext, 3'b100);
    wb_ready = 1'b1; step(); wb_ready = 1'b0;

    // Fill and stall, overflow, push while popping, ordered drain with wrap.
    for (int k = 0; k < 4; k++) begin
      drive_norm(3'(k), 8'h10 + 8'(k), 11'h000);
      step();
    end
    in_valid = 1'b0; #1;
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_head", write_data, 8'h10);
    chk("full_hold_reg", write_reg, 0);
    drive_norm(3'd6, 8'h14, 11'h000); #1;
    step(); in_valid = 1'b0; #1;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 4);
    chk("ovf_head_stable", write_data, 8'h10);
    drive_norm(3'd4, 8'h15, 11'h000); wb_ready = 1'b1; #1;
    chk("pushpop_in_ready", in_ready, 1);
    step(); in_valid = 1'b0; #1;
    chk("pushpop_count", count, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_%0d", k), write_data, exp_q[k]);
      step();
    end
    chk("drain_empty", count, 0);
    wb_ready = 1'b0;

    // Bypass: youngest match wins; non-match gives zero.
    drive_norm(3'd2, 8'h11, 11'h000); step();
    drive_norm(3'd2, 8'h22, 11'h000); step();
    drive_norm(3'd6, 8'h33, 11'h000); step();
    in_valid = 1'b0; q_reg = 3'd2; #1;
    chk("byp_hit", q_hit, 1);
    chk("byp_youngest", q_data, 8'h22);
    q_reg = 3'd4; #1;
    chk("byp_miss_hit", q_hit, 0);
    chk("byp_miss_data", q_data, 0);

    // Flush with 3 entries; overflow retained.
    chk("pre_flush_count", count, 3);
    flush = 1'b1; step(); flush = 1'b0; #1;
    chk("flush_count", count, 0);
    chk("flush_wb_valid", wb_valid, 0);
    chk("flush_overflow", overflow, 1);

    // A popping head drops out of the bypass.
    drive_norm(3'd7, 8'h44, 11'h000); step(); in_valid = 1'b0;
    q_reg = 3'd7; #1;
    chk("pop_byp_before", q_hit, 1);
    wb_ready = 1'b1; #1;
    chk("pop_byp_excluded", q_hit, 0);
    step(); wb_ready = 1'b0;

    // Reset mid-stream.
    drive_norm(3'd1, 8'h55, 11'h7FF); step();
    drive_norm(3'd2, 8'h66, 11'h7FF); step();
    in_valid = 1'b0; rst_n = 1'b0; step(); rst_n = 1'b1; #1;
    chk("rst2_count", count, 0);
    chk("rst2_wb_valid", wb_valid, 0);
    chk("rst2_wdata", {write_reg, write_data, write_data_ext}, 0);
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_overflow", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
